// File: rtl/vga_palette_pkg.sv
// Shared VGA palette definitions: colour table, pixel type and encoder states.
// Both the palette decoder and the nearest-colour encoder import this package.
package vga_palette_pkg;
    localparam int NUM_COLORS = 8;
    localparam int IDX_W      = 3;
    localparam int DIST_W     = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    // Entries 4 and 7 are both white; the encoder's strict compare picks 4.
    localparam rgb_t PALETTE [NUM_COLORS] = '{
        24'h205cd0, 24'hdbb369, 24'h23cee5, 24'h14b5e1,
        24'hffffff, 24'h712e23, 24'h2098dc, 24'hffffff
    };
endpackage

// File: rtl/rgb_manhattan_dist.sv
// Combinational Manhattan distance between two RGB pixels:
// |dr|+|dg|+|db|, each term 8 bits, summed zero-extended to DIST_W.
module rgb_manhattan_dist
    import vga_palette_pkg::*;
#(
    parameter int DIST_W = 10
) (
    input  rgb_t              i_a,
    input  rgb_t              i_b,
    output logic [DIST_W-1:0] o_dist
);
    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    logic [7:0] w_dr, w_dg, w_db;

    assign w_dr   = absdiff(i_a.r, i_b.r);
    assign w_dg   = absdiff(i_a.g, i_b.g);
    assign w_db   = absdiff(i_a.b, i_b.b);
    assign o_dist = DIST_W'(w_dr) + DIST_W'(w_dg) + DIST_W'(w_db);
endmodule

// File: rtl/vga_palette_encoder.sv
// Maps a 24-bit RGB pixel to the nearest 3-bit palette index by scanning
// one palette entry per cycle; valid/ready handshake on input and output.
module vga_palette_encoder
    import vga_palette_pkg::*;
#(
    parameter int NUM_COLORS = 8,
    parameter int IDX_W      = $clog2(NUM_COLORS),
    parameter int DIST_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DIST_W-1:0] out_dist
);
    state_t              r_state, w_next;
    rgb_t                r_pix;
    logic [IDX_W-1:0]    r_cnt, r_best_idx, r_out_idx;
    logic [DIST_W-1:0]   r_best_dist, r_out_dist;
    logic [DIST_W-1:0]   w_dist;
    logic                w_upd, w_last;

    rgb_manhattan_dist #(.DIST_W(DIST_W)) u_dist (
        .i_a    (r_pix),
        .i_b    (PALETTE[r_cnt]),
        .o_dist (w_dist)
    );

    // Strict less-than keeps the earliest entry on ties.
    assign w_upd  = (w_dist < r_best_dist);
    assign w_last = (r_cnt == IDX_W'(NUM_COLORS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = SCAN;
            end
            SCAN: if (w_last) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix       <= '0;
            r_cnt       <= '0;
            r_best_dist <= '1;
            r_best_idx  <= '0;
            r_out_idx   <= '0;
            r_out_dist  <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_pix       <= in_rgb;
                    r_cnt       <= '0;
                    r_best_dist <= '1;
                    r_best_idx  <= '0;
                end
                SCAN: begin
                    if (w_upd) begin
                        r_best_dist <= w_dist;
                        r_best_idx  <= r_cnt;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    // Final compare folds straight into the held result.
                    if (w_last) begin
                        r_out_idx  <= w_upd ? r_cnt  : r_best_idx;
                        r_out_dist <= w_upd ? w_dist : r_best_dist;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_idx  = r_out_idx;
    assign out_dist = r_out_dist;
endmodule

// File: tb/tb_vga_palette_encoder.sv
// Scoreboard bench for vga_palette_encoder: expected results are queued at
// acceptance and compared when the encoder completes an output handshake.
module tb_vga_palette_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_rgb = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_idx;
    logic [9:0]  out_dist;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [12:0] sb[$];

    vga_palette_encoder #(.NUM_COLORS(8), .IDX_W(3), .DIST_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rgb    (in_rgb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_dist  (out_dist)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference nearest-colour search with its own copy of the palette.
    function automatic logic [12:0] ref_enc(input logic [23:0] px);
        logic [23:0] pal [8];
        int best_d, best_i, d;
        pal = '{24'h205cd0, 24'hdbb369, 24'h23cee5, 24'h14b5e1,
                24'hffffff, 24'h712e23, 24'h2098dc, 24'hffffff};
        best_d = 1 << 20;
        best_i = 0;
        for (int i = 0; i < 8; i++) begin
            d = 0;
            for (int c = 0; c < 3; c++) begin
                int a, b;
                a = int'((px >> (8 * c)) & 24'hff);
                b = int'((pal[i] >> (8 * c)) & 24'hff);
                d += (a > b) ? a - b : b - a;
            end
            if (d < best_d) begin
                best_d = d;
                best_i = i;
            end
        end
        return {3'(best_i), 10'(best_d)};
    endfunction

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("spurious_out", 1, 0);
            else begin
                logic [12:0] e;
                e = sb.pop_front();
                chk("sb_idx", out_idx, e[12:10]);
                chk("sb_dist", out_dist, e[9:0]);
            end
        end
    end

    task automatic send(input logic [23:0] rgb, output int acc);
        bit done;
        done = 0;
        acc = -1;
        in_rgb = rgb;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(ref_enc(rgb));
                @(posedge clk);
                #1;
                acc = cyc;
                in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            chk("accept_timeout", 0, 1);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 50 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = n;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc1, acc2, lat;
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int acc1, acc2, lat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_dist", out_dist, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // exact match, latency
        send(24'h205cd0, acc1);
        wait_valid(lat);
        chk("latency", lat, 8);
        chk("t1_idx", out_idx, 0);
        chk("t1_dist", out_dist, 0);
        out_ready = 1'b1;
        drain();

        // white ties to lowest index
        out_ready = 1'b0;
        send(24'hffffff, acc1);
        wait_valid(lat);
        chk("t2_idx", out_idx, 4);
        chk("t2_dist", out_dist, 0);
        out_ready = 1'b1;
        drain();

        // black plus 5-cycle backpressure hold
        out_ready = 1'b0;
        send(24'h000000, acc1);
        wait_valid(lat);
        chk("t3_idx", out_idx, 5);
        chk("t3_dist", out_dist, 194);
        in_rgb = 24'h205cd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_idx", out_idx, 5);
            chk("hold_dist", out_dist, 194);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("hold_no_extra", sb.size(), 0);

        // reset mid-scan drops the pixel
        send(24'hdbb369, acc1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_idx", out_idx, 0);
        chk("midrst_out_dist", out_dist, 0);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_out", out_valid, 0);
        send(24'h14b5e1, acc1);
        wait_valid(lat);
        chk("t5_idx", out_idx, 3);
        drain();

        // back-to-back with in_rgb disturbed during scan
        send(24'h712e23, acc1);
        in_rgb = 24'hffffff;
        repeat (3) @(posedge clk);
        send(24'h2098dc, acc2);
        chk("b2b_spacing", acc2 - acc1, 10);
        in_rgb = 24'h000000;
        @(posedge clk);
        in_rgb = 24'hdbb369;
        drain();

        // random pixels under random backpressure
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(24'($urandom), acc1);
                    if (i == 3) send(24'h23cee5, acc1);
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom % 2);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
